// File: rtl/svc_axi_stripe_rd_gran.sv
// Read-only AXI bridge that stripes one manager burst across NUM_S subordinates in chunks of
// STRIPE_BEATS words, issuing one AR per subordinate and returning beats in original order.
module svc_axi_stripe_rd_gran #(
    parameter int unsigned NUM_S          = 2,
    parameter int unsigned STRIPE_BEATS   = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 21,
    parameter int unsigned AXI_DATA_WIDTH = 16,
    parameter int unsigned AXI_ID_WIDTH   = 4
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  s_axi_arvalid,
    output logic                                                  s_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]                               s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]                             s_axi_araddr,
    input  logic [7:0]                                            s_axi_arlen,
    input  logic [2:0]                                            s_axi_arsize,
    input  logic [1:0]                                            s_axi_arburst,
    output logic                                                  s_axi_rvalid,
    input  logic                                                  s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]                               s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]                             s_axi_rdata,
    output logic [1:0]                                            s_axi_rresp,
    output logic                                                  s_axi_rlast,
    output logic [NUM_S-1:0]                                      m_axi_arvalid,
    input  logic [NUM_S-1:0]                                      m_axi_arready,
    output logic [NUM_S*AXI_ID_WIDTH-1:0]                         m_axi_arid,
    output logic [NUM_S*(AXI_ADDR_WIDTH-$clog2(NUM_S))-1:0]       m_axi_araddr,
    output logic [NUM_S*8-1:0]                                    m_axi_arlen,
    output logic [NUM_S*3-1:0]                                    m_axi_arsize,
    output logic [NUM_S*2-1:0]                                    m_axi_arburst,
    input  logic [NUM_S-1:0]                                      m_axi_rvalid,
    output logic [NUM_S-1:0]                                      m_axi_rready,
    input  logic [NUM_S*AXI_ID_WIDTH-1:0]                         m_axi_rid,
    input  logic [NUM_S*AXI_DATA_WIDTH-1:0]                       m_axi_rdata,
    input  logic [NUM_S*2-1:0]                                    m_axi_rresp,
    input  logic [NUM_S-1:0]                                      m_axi_rlast
);

    localparam int unsigned SW  = $clog2(NUM_S);
    localparam int unsigned BW  = $clog2(AXI_DATA_WIDTH / 8);
    localparam int unsigned SBW = $clog2(STRIPE_BEATS);
    localparam int unsigned MAW = AXI_ADDR_WIDTH - SW;
    localparam int unsigned WW  = AXI_ADDR_WIDTH - BW;
    localparam int unsigned CW  = 9;
    localparam logic [WW-1:0] SB_MASK = WW'(STRIPE_BEATS - 1);

    typedef enum logic [2:0] {StIdle, StCalc, StIssue, StData, StErr} state_t;

    state_t                  state_q, state_d;
    logic                    init_q, init_d;
    logic [AXI_ID_WIDTH-1:0] id_q, id_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [WW-1:0]           w_q, w_d;
    logic [CW-1:0]           rem_q, rem_d;
    logic [CW-1:0]           beats_left_q, beats_left_d;
    logic [CW-1:0]           chunk_left_q, chunk_left_d;
    logic [SW-1:0]           cur_q, cur_d;
    logic [CW-1:0]           cnt_q [NUM_S];
    logic [CW-1:0]           cnt_d [NUM_S];
    logic [MAW-1:0]          start_q [NUM_S];
    logic [MAW-1:0]          start_d [NUM_S];
    logic [NUM_S-1:0]        pend_q, pend_d;

    logic [WW-1:0]           w0;
    logic                    ar_ok;
    logic [CW-1:0]           calc_offs, calc_avail, calc_take;
    logic [SW-1:0]           calc_s;

    // m_axi_rlast is ignored: the manager-side rlast comes from our own beat count.
    logic unused_ok;
    assign unused_ok = ^{m_axi_rid, m_axi_rlast};

    function automatic logic [SW-1:0] slave_of(input logic [WW-1:0] w);
        return SW'(w >> SBW);
    endfunction

    function automatic logic [MAW-1:0] local_byte(input logic [WW-1:0] w);
        return MAW'(AXI_ADDR_WIDTH'(((w >> (SBW + SW)) << SBW) | (w & SB_MASK)) << BW);
    endfunction

    assign w0    = WW'(s_axi_araddr >> BW);
    assign ar_ok = (s_axi_arburst == 2'b01) && (s_axi_arsize == 3'(BW));

    always_comb begin
        state_d       = state_q;
        init_d        = 1'b1;
        id_d          = id_q;
        size_d        = size_q;
        burst_d       = burst_q;
        w_d           = w_q;
        rem_d         = rem_q;
        beats_left_d  = beats_left_q;
        chunk_left_d  = chunk_left_q;
        cur_d         = cur_q;
        cnt_d         = cnt_q;
        start_d       = start_q;
        pend_d        = pend_q;
        calc_offs     = '0;
        calc_avail    = '0;
        calc_take     = '0;
        calc_s        = '0;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rid     = id_q;
        s_axi_rdata   = '0;
        s_axi_rresp   = 2'b00;
        s_axi_rlast   = 1'b0;
        m_axi_rready  = '0;

        case (state_q)
            StIdle: begin
                s_axi_arready = init_q;
                if (s_axi_arvalid && init_q) begin
                    id_d         = s_axi_arid;
                    size_d       = s_axi_arsize;
                    burst_d      = s_axi_arburst;
                    w_d          = w0;
                    rem_d        = CW'(s_axi_arlen) + CW'(1);
                    beats_left_d = CW'(s_axi_arlen) + CW'(1);
                    cur_d        = slave_of(w0);
                    chunk_left_d = CW'(STRIPE_BEATS) - CW'(w0 & SB_MASK);
                    for (int s = 0; s < NUM_S; s++) cnt_d[s] = '0;
                    state_d      = ar_ok ? StCalc : StErr;
                end
            end
            // One chunk per cycle: accumulate its beats onto the owning subordinate.
            StCalc: begin
                calc_offs  = CW'(w_q & SB_MASK);
                calc_avail = CW'(STRIPE_BEATS) - calc_offs;
                calc_take  = (rem_q < calc_avail) ? rem_q : calc_avail;
                calc_s     = slave_of(w_q);
                if (cnt_q[calc_s] == '0) start_d[calc_s] = local_byte(w_q);
                cnt_d[calc_s] = cnt_q[calc_s] + calc_take;
                w_d   = w_q + WW'(calc_take);
                rem_d = rem_q - calc_take;
                if (rem_q == calc_take) begin
                    for (int s = 0; s < NUM_S; s++) pend_d[s] = (cnt_d[s] != '0);
                    state_d = StIssue;
                end
            end
            StIssue: begin
                pend_d = pend_q & ~m_axi_arready;
                if (pend_d == '0) state_d = StData;
            end
            StData: begin
                s_axi_rvalid         = m_axi_rvalid[cur_q];
                s_axi_rdata          = m_axi_rdata[int'(cur_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                s_axi_rresp          = m_axi_rresp[int'(cur_q)*2 +: 2];
                s_axi_rlast          = (beats_left_q == CW'(1));
                m_axi_rready[cur_q]  = s_axi_rready;
                if (s_axi_rvalid && s_axi_rready) begin
                    beats_left_d = beats_left_q - CW'(1);
                    if (chunk_left_q == CW'(1)) begin
                        cur_d        = cur_q + SW'(1);
                        chunk_left_d = CW'(STRIPE_BEATS);
                    end else begin
                        chunk_left_d = chunk_left_q - CW'(1);
                    end
                    if (beats_left_q == CW'(1)) state_d = StIdle;
                end
            end
            StErr: begin
                s_axi_rvalid = 1'b1;
                s_axi_rresp  = 2'b10;
                s_axi_rlast  = (beats_left_q == CW'(1));
                if (s_axi_rready) begin
                    beats_left_d = beats_left_q - CW'(1);
                    if (beats_left_q == CW'(1)) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign m_axi_arvalid = pend_q;

    always_comb begin
        m_axi_arid    = '0;
        m_axi_araddr  = '0;
        m_axi_arlen   = '0;
        m_axi_arsize  = '0;
        m_axi_arburst = '0;
        for (int s = 0; s < NUM_S; s++) begin
            m_axi_arid[s*AXI_ID_WIDTH +: AXI_ID_WIDTH] = id_q;
            m_axi_araddr[s*MAW +: MAW]                 = start_q[s];
            m_axi_arlen[s*8 +: 8]                      = 8'(cnt_q[s] - CW'(1));
            m_axi_arsize[s*3 +: 3]                     = size_q;
            m_axi_arburst[s*2 +: 2]                    = burst_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            init_q       <= 1'b0;
            id_q         <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            w_q          <= '0;
            rem_q        <= '0;
            beats_left_q <= '0;
            chunk_left_q <= '0;
            cur_q        <= '0;
            pend_q       <= '0;
            for (int s = 0; s < NUM_S; s++) begin
                cnt_q[s]   <= '0;
                start_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            init_q       <= init_d;
            id_q         <= id_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
            w_q          <= w_d;
            rem_q        <= rem_d;
            beats_left_q <= beats_left_d;
            chunk_left_q <= chunk_left_d;
            cur_q        <= cur_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
        end
    end

endmodule
